e203_exu_wbck_sched: RTL

- Write-back scheduler in front of the single integer regfile write port.
- Shares the port between the 1-cycle ALU and NREQ long-pipe requesters (LSU, MULDIV, NICE): round-robin among long-pipe requesters, long-pipe priority over ALU.
- A starvation counter guarantees ALU forward progress.
- Grants are combinational; the regfile write is registered, one cycle after the grant.

---
 rtl/e203_exu_wbck_sched_pkg.sv | 17 +
 rtl/e203_exu_wbck_sched_rrarb.sv | 37 +++
 rtl/e203_exu_wbck_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/e203_exu_wbck_sched_pkg.sv
// Shared widths and defaults for the integer write-back scheduler.
// The winner encoding names which side owns the regfile port this cycle.
package e203_exu_wbck_sched_pkg;

  localparam int NREQ_DEF       = 3;
  localparam int XLEN_DEF       = 32;
  localparam int RFIDX_W_DEF    = 5;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_ALU  = 2'd1,
    WIN_LP   = 2'd2
  } win_e;

endpackage

// File: rtl/e203_exu_wbck_sched_rrarb.sv
// Combinational round-robin picker: first asserted request at or after i_ptr.
// The pointer register lives in the parent so the picker stays stateless.
module e203_exu_wbck_sched_rrarb
  import e203_exu_wbck_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (i_req[f_wrap(i_ptr, off)]) begin
        o_idx = f_wrap(i_ptr, off);
        o_gnt = NREQ'(1) << f_wrap(i_ptr, off);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/e203_exu_wbck_sched.sv
// Write-back scheduler sharing the single integer regfile write port between
// the ALU and long-pipe requesters; the regfile write is registered one cycle late.
module e203_exu_wbck_sched
  import e203_exu_wbck_sched_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int XLEN       = XLEN_DEF,
  parameter int RFIDX_W    = RFIDX_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_wbck_i_valid,
  output logic                    alu_wbck_i_ready,
  input  logic [XLEN-1:0]         alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]      alu_wbck_i_rdidx,
  input  logic [NREQ-1:0]         lp_wbck_i_valid,
  output logic [NREQ-1:0]         lp_wbck_i_ready,
  input  logic [NREQ*XLEN-1:0]    lp_wbck_i_wdat,
  input  logic [NREQ*RFIDX_W-1:0] lp_wbck_i_rdidx,
  input  logic [NREQ-1:0]         lp_wbck_i_rdfpu,
  output logic                    rf_wbck_o_ena,
  output logic [XLEN-1:0]         rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0]      rf_wbck_o_rdidx,
  output logic                    alu_starve_o
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_rr_ptr_nxt;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic [CNT_W-1:0]   w_starve_nxt;
  logic [NREQ-1:0]    w_arb_gnt;
  logic [PTR_W-1:0]   w_arb_idx;
  logic               w_arb_any;
  logic               w_force;
  win_e               w_win;
  logic [XLEN-1:0]    w_win_wdat;
  logic [RFIDX_W-1:0] w_win_rdidx;
  logic               w_win_fpu;

  e203_exu_wbck_sched_rrarb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rrarb (
    .i_req (lp_wbck_i_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // A pending forced grant overrides every long-pipe request.
  always_comb begin
    w_force = alu_wbck_i_valid & (r_starve_cnt == CNT_MAX);
    w_win   = WIN_NONE;
    if (w_force)               w_win = WIN_ALU;
    else if (w_arb_any)        w_win = WIN_LP;
    else if (alu_wbck_i_valid) w_win = WIN_ALU;

    alu_wbck_i_ready = (w_win == WIN_ALU);
    lp_wbck_i_ready  = (w_win == WIN_LP) ? w_arb_gnt : '0;

    w_win_wdat  = alu_wbck_i_wdat;
    w_win_rdidx = alu_wbck_i_rdidx;
    w_win_fpu   = 1'b0;
    if (w_win == WIN_LP) begin
      w_win_wdat  = lp_wbck_i_wdat[int'(w_arb_idx)*XLEN +: XLEN];
      w_win_rdidx = lp_wbck_i_rdidx[int'(w_arb_idx)*RFIDX_W +: RFIDX_W];
      w_win_fpu   = lp_wbck_i_rdfpu[w_arb_idx];
    end

    w_starve_nxt = '0;
    if (alu_wbck_i_valid && (w_win != WIN_ALU))
      w_starve_nxt = (r_starve_cnt == CNT_MAX) ? r_starve_cnt : r_starve_cnt + CNT_W'(1);

    w_rr_ptr_nxt = r_rr_ptr;
    if (w_win == WIN_LP)
      w_rr_ptr_nxt = (w_arb_idx == PTR_W'(NREQ - 1)) ? '0 : w_arb_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr        <= '0;
      r_starve_cnt    <= '0;
      alu_starve_o    <= 1'b0;
      rf_wbck_o_ena   <= 1'b0;
      rf_wbck_o_wdat  <= '0;
      rf_wbck_o_rdidx <= '0;
    end else begin
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_starve_cnt  <= w_starve_nxt;
      alu_starve_o  <= (w_starve_nxt == CNT_MAX);
      // FPU-destined transfers still use the slot but never write the integer file.
      rf_wbck_o_ena <= (w_win != WIN_NONE) & ~w_win_fpu;
      if (w_win != WIN_NONE) begin
        rf_wbck_o_wdat  <= w_win_wdat;
        rf_wbck_o_rdidx <= w_win_rdidx;
      end
    end
  end

endmodule
